// File: rtl/dual_port_ram_core.sv
// dual_port_ram_core
//   Single-clock true dual-port RAM, 2**ADDR words of DATA bits.
//   Registered read with read-first behaviour on both ports: a read returns
//   the content from before this edge's writes, on either port.
//   When both ports write the same address, port A wins.
//   Memory powers up zeroed. rst clears only the output registers and blocks
//   writes while it is high.
//
//   Build option: define DPRAM_OUTREG_EN to add a second output register
//   stage. Read latency then becomes 2 cycles.
//
// Ports
//   clk            clock, rising edge
//   rst            async active-high reset of the output registers
//   wea/addra/dina port A write enable, address, write data
//   douta          port A registered read data
//   web/addrb/dinb port B write enable, address, write data
//   doutb          port B registered read data
//   coll           registered flag: last cycle had addra==addrb with a write
module dual_port_ram_core #(
  parameter int DATA = 64,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wea,
  input  logic [ADDR-1:0] addra,
  input  logic [DATA-1:0] dina,
  output logic [DATA-1:0] douta,
  input  logic            web,
  input  logic [ADDR-1:0] addrb,
  input  logic [DATA-1:0] dinb,
  output logic [DATA-1:0] doutb,
  output logic            coll
);

  localparam int DEPTH = 2**ADDR;

  typedef struct packed {
    logic [DATA-1:0] a;
    logic [DATA-1:0] b;
    logic            coll;
  } rd_t;

  // Zero power-up contents; rst never touches the array.
  logic [DATA-1:0] mem [DEPTH] = '{default: '0};

  rd_t  s1;
  logic same_addr;
  logic wr_b_ok;

  assign same_addr = (addra == addrb);
  // Port B yields to port A on a same-address double write.
  assign wr_b_ok   = web & ~(wea & same_addr);

  // The array write lives in the reset process, so rst high on an edge
  // suppresses that edge's writes. The reset branch leaves mem alone.
  // Non-blocking reads of mem give read-first on both ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.a    <= mem[addra];
      s1.b    <= mem[addrb];
      s1.coll <= same_addr & (wea | web);
      if (wea)     mem[addra] <= dina;
      if (wr_b_ok) mem[addrb] <= dinb;
    end
  end

`ifdef DPRAM_OUTREG_EN
  rd_t s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s2 <= '0;
    else     s2 <= s1;
  end

  assign douta = s2.a;
  assign doutb = s2.b;
  assign coll  = s2.coll;
`else
  assign douta = s1.a;
  assign doutb = s1.b;
  assign coll  = s1.coll;
`endif

endmodule

// File: tb/tb_dual_port_ram_core.sv
// tb_dual_port_ram_core
//   Directed bench for dual_port_ram_core at DATA=64, ADDR=10.
//   LAT follows DPRAM_OUTREG_EN, so one sequence covers both builds.
module tb_dual_port_ram_core;

  localparam int DATA = 64;
  localparam int ADDR = 10;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wea;
  logic [ADDR-1:0] addra;
  logic [DATA-1:0] dina;
  logic [DATA-1:0] douta;
  logic            web;
  logic [ADDR-1:0] addrb;
  logic [DATA-1:0] dinb;
  logic [DATA-1:0] doutb;
  logic            coll;

  int checks = 0;
  int errors = 0;

  dual_port_ram_core #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk  (clk),
    .rst  (rst),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .douta(douta),
    .web  (web),
    .addrb(addrb),
    .dinb (dinb),
    .doutb(doutb),
    .coll (coll)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wa, input logic [ADDR-1:0] aa, input logic [DATA-1:0] da,
                       input logic wb, input logic [ADDR-1:0] ab, input logic [DATA-1:0] db);
    wea = wa; addra = aa; dina = da;
    web = wb; addrb = ab; dinb = db;
  endtask

  task automatic chk(input string tag, input logic [DATA-1:0] obs, input logic [DATA-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    #2;
    chk("reset_douta", douta, 64'h0);
    chk("reset_doutb", doutb, 64'h0);
    chk("reset_coll",  {63'h0, coll}, 64'h0);
    tick();
    rst = 1'b0;

    // Load addr 5 = 0x55 and addr 6 = 0xAAAA.
    drive(1, 10'd5, 64'h55, 0, 10'd0, '0);
    tick();
    drive(1, 10'd6, 64'hAAAA, 0, 10'd0, '0);
    tick();
    // B rewrites addr 6 with the same value, so coll goes high.
    // A reads 6 on the same cycles.
    drive(0, 10'd6, '0, 1, 10'd6, 64'hAAAA);
    repeat (LAT) tick();
    chk("pre_rst_douta", douta, 64'hAAAA);
    chk("pre_rst_coll",  {63'h0, coll}, 64'h1);

    // Assert reset between edges; outputs clear without a clock.
    drive(0, 10'd6, '0, 0, 10'd6, '0);
    rst = 1'b1;
    #2;
    chk("async_rst_douta", douta, 64'h0);
    chk("async_rst_doutb", doutb, 64'h0);
    chk("async_rst_coll",  {63'h0, coll}, 64'h0);
    // A write attempted under reset must be dropped.
    drive(1, 10'd5, 64'hFF, 0, 10'd0, '0);
    tick();
    rst = 1'b0;
    drive(0, 10'd5, '0, 0, 10'd0, '0);
    repeat (LAT) tick();
    chk("post_rst_read5", douta, 64'h55);

    // Basic write on A, then read on B. Addr 7 was never written.
    drive(1, 10'd3, 64'h1234, 0, 10'd7, '0);
    tick();
    drive(0, 10'd7, '0, 0, 10'd3, '0);
    tick();
    chk("basic_doutb_edge1", doutb, (LAT == 1) ? 64'h1234 : 64'h0);
    tick();
    chk("basic_doutb", doutb, 64'h1234);
    chk("unwritten_7", douta, 64'h0);

    // Read-first: mem[9]=0x11. A writes 0x22 while B reads 9.
    drive(1, 10'd9, 64'h11, 0, 10'd0, '0);
    tick();
    drive(1, 10'd9, 64'h22, 0, 10'd9, '0);
    tick();
    drive(0, 10'd9, '0, 0, 10'd9, '0);
    repeat (LAT - 1) tick();
    chk("rf_douta_old", douta, 64'h11);
    chk("rf_doutb_old", doutb, 64'h11);
    chk("rf_coll",      {63'h0, coll}, 64'h1);
    tick();
    chk("rf_douta_new", douta, 64'h22);
    chk("rf_doutb_new", doutb, 64'h22);
    chk("rf_coll_clr",  {63'h0, coll}, 64'h0);

    // Double write to addr 4: A's 0xA must win.
    drive(1, 10'd4, 64'hA, 1, 10'd4, 64'hB);
    tick();
    drive(0, 10'd4, '0, 0, 10'd4, '0);
    repeat (LAT - 1) tick();
    chk("ww_coll",  {63'h0, coll}, 64'h1);
    chk("ww_douta_old", douta, 64'h0);
    chk("ww_doutb_old", doutb, 64'h0);
    tick();
    chk("ww_douta", douta, 64'hA);
    chk("ww_doutb", doutb, 64'hA);

    // Independent writes at the two extreme addresses.
    drive(1, 10'd0, 64'hC0DE, 1, 10'd1023, 64'hBEEF);
    tick();
    drive(0, 10'd0, '0, 0, 10'd1023, '0);
    repeat (LAT - 1) tick();
    chk("ind_coll", {63'h0, coll}, 64'h0);
    tick();
    chk("ind_douta", douta, 64'hC0DE);
    chk("ind_doutb", doutb, 64'hBEEF);
    drive(0, 10'd1023, '0, 0, 10'd0, '0);
    repeat (LAT) tick();
    chk("ind_swap_douta", douta, 64'hBEEF);
    chk("ind_swap_doutb", doutb, 64'hC0DE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
